// File: rtl/ysyx_24110015_pkg.sv
// ysyx_24110015_pkg: shared types and constants for the memory-access scheduler
package ysyx_24110015_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } sched_state_t;

    typedef enum logic {
        OWN_IFU,
        OWN_LSU
    } owner_t;

    localparam logic [2:0] SIZE_WORD = 3'b010;

endpackage

// File: rtl/ysyx_24110015_sched_arb.sv
// ysyx_24110015_sched_arb: LSU-priority grant logic with optional IFU aging (macro YSYX_24110015_SCHED_AGING_EN)
module ysyx_24110015_sched_arb #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic idle,
    input  logic ifu_valid,
    input  logic lsu_valid,
    output logic grant_ifu,
    output logic grant_lsu
);

`ifdef YSYX_24110015_SCHED_AGING_EN
    logic [2:0] age;
    logic       force_ifu;

    assign force_ifu = ifu_valid && (age >= 3'(STARVE_LIMIT));
    assign grant_lsu = idle && lsu_valid && !force_ifu;
    assign grant_ifu = idle && ifu_valid && !grant_lsu;

    // count LSU grants that made a waiting IFU stand aside; saturate at 7
    always_ff @(posedge clock) begin
        if (reset)
            age <= '0;
        else if (grant_ifu)
            age <= '0;
        else if (grant_lsu && ifu_valid && age != 3'd7)
            age <= age + 3'd1;
    end
`else
    localparam int unused_starve_limit = STARVE_LIMIT;

    logic unused_clk_rst;
    assign unused_clk_rst = clock ^ reset;

    assign grant_lsu = idle && lsu_valid;
    assign grant_ifu = idle && ifu_valid && !lsu_valid;
`endif

endmodule

// File: rtl/ysyx_24110015_mem_sched.sv
// ysyx_24110015_mem_sched: single-outstanding IFU/LSU memory scheduler (optional aging via YSYX_24110015_SCHED_AGING_EN)
module ysyx_24110015_mem_sched
    import ysyx_24110015_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_req_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_resp_data,
    output logic                ifu_resp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic                lsu_req_we,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wstrb,
    input  logic [2:0]          lsu_req_size,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_resp_data,
    output logic                lsu_resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_we,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wstrb,
    output logic [2:0]          mem_req_size,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data,
    input  logic                mem_resp_err
);

    sched_state_t state;
    owner_t       owner;
    logic         grant_ifu;
    logic         grant_lsu;
    logic         resp_hit;

    ysyx_24110015_sched_arb #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_arb (
        .clock    (clock),
        .reset    (reset),
        .idle     (state == IDLE),
        .ifu_valid(ifu_req_valid),
        .lsu_valid(lsu_req_valid),
        .grant_ifu(grant_ifu),
        .grant_lsu(grant_lsu)
    );

    assign ifu_req_ready = grant_ifu;
    assign lsu_req_ready = grant_lsu;

    // responses are routed straight through to whoever owns the transaction
    assign resp_hit       = (state == WAIT) && mem_resp_valid;
    assign ifu_resp_valid = resp_hit && owner == OWN_IFU;
    assign ifu_resp_data  = ifu_resp_valid ? mem_resp_data : '0;
    assign ifu_resp_err   = ifu_resp_valid && mem_resp_err;
    assign lsu_resp_valid = resp_hit && owner == OWN_LSU;
    assign lsu_resp_data  = (lsu_resp_valid && !mem_req_we) ? mem_resp_data : '0;
    assign lsu_resp_err   = lsu_resp_valid && mem_resp_err;

    // scheduler FSM: latch the winner, hold it on the bus until accepted, then await the response
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            owner         <= OWN_IFU;
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_wstrb <= '0;
            mem_req_size  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_lsu) begin
                        state         <= ISSUE;
                        owner         <= OWN_LSU;
                        mem_req_valid <= 1'b1;
                        mem_req_we    <= lsu_req_we;
                        mem_req_addr  <= lsu_req_addr;
                        mem_req_wdata <= lsu_req_wdata;
                        mem_req_wstrb <= lsu_req_wstrb;
                        mem_req_size  <= lsu_req_size;
                    end else if (grant_ifu) begin
                        state         <= ISSUE;
                        owner         <= OWN_IFU;
                        mem_req_valid <= 1'b1;
                        mem_req_we    <= 1'b0;
                        mem_req_addr  <= ifu_req_addr;
                        mem_req_wdata <= '0;
                        mem_req_wstrb <= '0;
                        mem_req_size  <= SIZE_WORD;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        state         <= WAIT;
                        mem_req_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // a response is only legal while a transaction is waiting for one
    assert property (@(posedge clock) disable iff (reset) mem_resp_valid |-> state == WAIT)
        else $error("mem_sched: unexpected mem_resp_valid outside WAIT");

endmodule
